i2c_req_arbiter: RTL

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c master between N_REQ requesters.
// Latency: grant and command fields one cycle after a request is seen in IDLE.
// Backpressure: losers hold req until granted; the winner is held until m_busy drops or timeout.
module i2c_req_arbiter #(
    parameter int N_REQ        = 4,
    parameter int START_CYCLES = 20,
    parameter int TIMEOUT      = 65535
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_r_w,
    input  logic [7*N_REQ-1:0]   req_s_add,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 m_r_w,
    output logic [6:0]           m_s_add,
    output logic [7:0]           m_data,
    output logic                 m_start_cond,
    input  logic                 m_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             saw_busy_q, saw_busy_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             m_r_w_q, m_r_w_d;
    logic [6:0]       m_s_add_q, m_s_add_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_start_cond_q, m_start_cond_d;

    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic             pick_r_w;
    logic [6:0]       pick_s_add;
    logic [7:0]       pick_data;
    logic [IDX_W-1:0] ptr_next;

    // Scan from the highest offset down so the last hit is the one nearest ptr.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] idx;
        pick     = ptr_q;
        pick_vld = 1'b0;
        j        = 0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            idx = IDX_W'(j);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_r_w   = 1'b0;
        pick_s_add = '0;
        pick_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_r_w   = req_r_w[i];
                pick_s_add = req_s_add[7*i +: 7];
                pick_data  = req_data[8*i +: 8];
            end
        end
    end

    assign ptr_next = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        win_d          = win_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        saw_busy_d     = saw_busy_q;
        gnt_d          = gnt_q;
        done_d         = '0;
        err_d          = '0;
        m_r_w_d        = m_r_w_q;
        m_s_add_d      = m_s_add_q;
        m_data_d       = m_data_q;
        m_start_cond_d = m_start_cond_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    win_d          = pick;
                    gnt_d          = N_REQ'(1) << pick;
                    m_r_w_d        = pick_r_w;
                    m_s_add_d      = pick_s_add;
                    m_data_d       = pick_data;
                    m_start_cond_d = 1'b1;
                    cnt_d          = '0;
                    tmo_d          = '0;
                    saw_busy_d     = 1'b0;
                    state_d        = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 16'd1;
                tmo_d = tmo_q + 16'd1;
                if (m_busy) begin
                    saw_busy_d = 1'b1;
                end
                if (cnt_q == START_LAST) begin
                    m_start_cond_d = 1'b0;
                    state_d        = S_BUSY;
                end
            end
            S_BUSY: begin
                tmo_d = tmo_q + 16'd1;
                if (m_busy) begin
                    saw_busy_d = 1'b1;
                end
                // Completion is tested first so it beats a simultaneous timeout.
                if (saw_busy_q && !m_busy) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            win_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            saw_busy_q     <= 1'b0;
            gnt_q          <= '0;
            done_q         <= '0;
            err_q          <= '0;
            m_r_w_q        <= 1'b0;
            m_s_add_q      <= '0;
            m_data_q       <= '0;
            m_start_cond_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            win_q          <= win_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            saw_busy_q     <= saw_busy_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            err_q          <= err_d;
            m_r_w_q        <= m_r_w_d;
            m_s_add_q      <= m_s_add_d;
            m_data_q       <= m_data_d;
            m_start_cond_q <= m_start_cond_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign m_r_w        = m_r_w_q;
    assign m_s_add      = m_s_add_q;
    assign m_data       = m_data_q;
    assign m_start_cond = m_start_cond_q;

endmodule
